// File: rtl/relu_maxpool.sv
// ----------------------------------------------------------------------------
// relu_maxpool
//   Streaming post-convolution stage. Takes one feature-map pixel per cycle
//   (all channels, raster order), applies ReLU, then 2x2 stride-2 max pooling
//   using a single pooled-row line buffer. Emits one pooled pixel (all
//   channels) plus its pooled coordinates for every completed window.
//
// Ports
//   clk          posedge clock
//   rst_cnn      asynchronous, active-low reset
//   frame_start  single-cycle pulse: clear counters/line buffer, arm a frame
//   in_valid     in_data valid this cycle
//   in_data      one pixel, NUM_FEATURES signed channels of DATA_W bits
//   out_valid    out_data/out_row/out_col valid this cycle
//   out_data     pooled maxima (always >= 0)
//   out_row      pooled row index
//   out_col      pooled column index
//   frame_done   pulse one cycle after the last pixel of a frame is accepted
//   busy         high while a frame is being received
// ----------------------------------------------------------------------------
module relu_maxpool #(
  parameter int NUM_FEATURES = 10,
  parameter int IN_WIDTH     = 26,
  parameter int IN_HEIGHT    = 26,
  parameter int DATA_W       = 32,
  localparam int OUT_WIDTH   = IN_WIDTH / 2,
  localparam int OUT_HEIGHT  = IN_HEIGHT / 2,
  localparam int ROW_W       = $clog2(OUT_HEIGHT + 1),
  localparam int COL_W       = $clog2(OUT_WIDTH + 1)
) (
  input  logic                                      clk,
  input  logic                                      rst_cnn,
  input  logic                                      frame_start,
  input  logic                                      in_valid,
  input  logic signed [NUM_FEATURES-1:0][DATA_W-1:0] in_data,
  output logic                                      out_valid,
  output logic signed [NUM_FEATURES-1:0][DATA_W-1:0] out_data,
  output logic [ROW_W-1:0]                          out_row,
  output logic [COL_W-1:0]                          out_col,
  output logic                                      frame_done,
  output logic                                      busy
);

  localparam int RC_W  = $clog2(IN_HEIGHT + 1);
  localparam int CC_W  = $clog2(IN_WIDTH + 1);
  localparam int LB_AW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic [NUM_FEATURES-1:0][DATA_W-1:0] pix_t;

  state_t            state_q;
  logic [RC_W-1:0]   row_q, row_d, pix_row;
  logic [CC_W-1:0]   col_q, col_d, pix_col;
  logic              accept, last_pix, in_pool;
  logic [LB_AW-1:0]  pc;
  pix_t              lb_q [OUT_WIDTH];
  pix_t              relu_v, max_v;

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Pixel position and per-channel ReLU / running maximum
  always_comb begin
    // frame_start re-arms the counters, so a pixel arriving with it is (0,0)
    accept   = in_valid && (frame_start || (state_q == RUN));
    pix_row  = frame_start ? '0 : row_q;
    pix_col  = frame_start ? '0 : col_q;
    last_pix = (pix_row == RC_W'(IN_HEIGHT - 1)) && (pix_col == CC_W'(IN_WIDTH - 1));
    // odd trailing row/column never belongs to a full 2x2 window
    in_pool  = (pix_row < RC_W'(2 * OUT_HEIGHT)) && (pix_col < CC_W'(2 * OUT_WIDTH));
    pc       = LB_AW'(pix_col >> 1);

    row_d = pix_row;
    col_d = pix_col;
    if (accept) begin
      if (pix_col == CC_W'(IN_WIDTH - 1)) begin
        col_d = '0;
        row_d = pix_row + RC_W'(1);
      end else begin
        col_d = pix_col + CC_W'(1);
      end
    end

    relu_v = '0;
    max_v  = '0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      relu_v[f] = relu(in_data[f]);
      max_v[f]  = smax(lb_q[pc][f], relu_v[f]);
    end
  end

  // Control FSM, line buffer update and registered outputs
  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
      for (int i = 0; i < OUT_WIDTH; i++) lb_q[i] <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      row_q      <= row_d;
      col_q      <= col_d;

      if (frame_start) begin
        for (int i = 0; i < OUT_WIDTH; i++) lb_q[i] <= '0;
      end

      if (accept && in_pool) begin
        if (!pix_row[0] && !pix_col[0]) begin
          lb_q[pc] <= relu_v;
        end else if (pix_row[0] && pix_col[0]) begin
          out_data  <= max_v;
          out_row   <= ROW_W'(pix_row >> 1);
          out_col   <= COL_W'(pix_col >> 1);
          out_valid <= 1'b1;
        end else begin
          lb_q[pc] <= max_v;
        end
      end

      if (accept && last_pix) begin
        state_q    <= DONE;
        busy       <= 1'b0;
        frame_done <= 1'b1;
      end else if (frame_start) begin
        state_q <= RUN;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// ----------------------------------------------------------------------------
// tb_relu_maxpool
//   Directed bench for relu_maxpool. Two instances share the clock/reset:
//   index 0 is a 4x4 map, index 1 a 5x5 map, both with 4 channels of 32 bits.
//   Expected outputs come from hand-computed tables.
// ----------------------------------------------------------------------------
module tb_relu_maxpool;

  logic         clk = 1'b0;
  logic         rst_cnn = 1'b0;
  logic         fs [2];
  logic         iv [2];
  logic [127:0] id [2];
  logic         ov [2];
  logic [127:0] od [2];
  logic [1:0]   orow [2];
  logic [1:0]   ocol [2];
  logic         fd [2];
  logic         bz [2];

  int tests_run    = 0;
  int tests_failed = 0;

  // closing-pixel indices per instance, and expected window maxima
  int close_tbl [2][4] = '{'{5, 7, 13, 15}, '{6, 8, 16, 18}};
  int ramp4_val [4]    = '{6, 8, 14, 16};
  int ramp5_val [4]    = '{7, 9, 17, 19};
  int exp_r     [4]    = '{0, 0, 1, 1};
  int exp_c     [4]    = '{0, 1, 0, 1};

  always #5 clk = ~clk;

  relu_maxpool #(.NUM_FEATURES(4), .IN_WIDTH(4), .IN_HEIGHT(4), .DATA_W(32)) dut_a (
    .clk(clk), .rst_cnn(rst_cnn), .frame_start(fs[0]), .in_valid(iv[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_row(orow[0]), .out_col(ocol[0]),
    .frame_done(fd[0]), .busy(bz[0]));

  relu_maxpool #(.NUM_FEATURES(4), .IN_WIDTH(5), .IN_HEIGHT(5), .DATA_W(32)) dut_b (
    .clk(clk), .rst_cnn(rst_cnn), .frame_start(fs[1]), .in_valid(iv[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_row(orow[1]), .out_col(ocol[1]),
    .frame_done(fd[1]), .busy(bz[1]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
  endfunction

  // mode 0: 4x4 ramp, mode 1: 5x5 ramp, mode 2: 4x4 negatives with channel 3 hot
  function automatic logic [127:0] pix_data(input int mode, input int p);
    int c3;
    if (mode != 2) return pack4(p + 1, p + 1, p + 1, p + 1);
    case (p)
      0:       c3 = -1;
      1:       c3 = -2;
      4:       c3 = -3;
      5:       c3 = 7;
      default: c3 = -5;
    endcase
    return pack4(-5, -5, -5, c3);
  endfunction

  function automatic logic [127:0] exp_data(input int mode, input int k);
    if (mode == 0) return pack4(ramp4_val[k], ramp4_val[k], ramp4_val[k], ramp4_val[k]);
    if (mode == 1) return pack4(ramp5_val[k], ramp5_val[k], ramp5_val[k], ramp5_val[k]);
    return (k == 0) ? pack4(0, 0, 0, 7) : pack4(0, 0, 0, 0);
  endfunction

  // drive one cycle on instance d, sample 1 time unit after the edge
  task automatic step(input int d, input logic f, input logic v, input logic [127:0] x);
    fs[d] = f;
    iv[d] = v;
    id[d] = x;
    @(posedge clk);
    #1;
    fs[d] = 1'b0;
    iv[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input int mode, input bit fs_first, input bit gap);
    int w;
    int n;
    int k;
    w = (d == 1) ? 5 : 4;
    n = w * w;
    k = 0;
    if (!fs_first) begin
      step(d, 1'b1, 1'b0, '0);
      chk("busy_armed", bz[d], 1'b1);
    end
    for (int p = 0; p < n; p++) begin
      step(d, fs_first && (p == 0), 1'b1, pix_data(mode, p));
      if (k < 4 && p == close_tbl[d][k]) begin
        chk("out_valid_hi", ov[d], 1'b1);
        chk("out_data", od[d], exp_data(mode, k));
        chk("out_row", orow[d], 2'(exp_r[k]));
        chk("out_col", ocol[d], 2'(exp_c[k]));
        k++;
      end else begin
        chk("out_valid_lo", ov[d], 1'b0);
      end
      chk("frame_done", fd[d], (p == n - 1));
      chk("busy", bz[d], (p != n - 1));
      if (gap && p != n - 1) begin
        step(d, 1'b0, 1'b0, pack4(-99, 99, -99, 99));
        chk("gap_valid", ov[d], 1'b0);
        chk("gap_done", fd[d], 1'b0);
        if (k > 0) chk("gap_hold", od[d], exp_data(mode, k - 1));
      end
    end
    chk("win_count", 32'(k), 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0;
      iv[i] = 1'b0;
      id[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", ov[i], 1'b0);
      chk("rst_data", od[i], '0);
      chk("rst_row", orow[i], 2'd0);
      chk("rst_col", ocol[i], 2'd0);
      chk("rst_done", fd[i], 1'b0);
      chk("rst_busy", bz[i], 1'b0);
    end
    @(negedge clk);
    rst_cnn = 1'b1;

    // 4x4 ramp, back-to-back
    run_frame(0, 0, 1'b0, 1'b0);

    // in DONE, in_valid without frame_start is ignored
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'b1, pack4(50, 50, 50, 50));
      chk("done_ignore_valid", ov[0], 1'b0);
      chk("done_ignore_busy", bz[0], 1'b0);
      chk("done_ignore_fd", fd[0], 1'b0);
    end

    // negatives, first pixel arrives with frame_start
    run_frame(0, 2, 1'b1, 1'b0);

    // 4x4 ramp with in_valid toggling
    run_frame(0, 0, 1'b0, 1'b1);

    // 5x5 ramp, trailing row/column discarded
    run_frame(1, 1, 1'b0, 1'b0);

    // asynchronous reset during the 10th pixel
    step(0, 1'b1, 1'b0, '0);
    for (int p = 0; p < 9; p++) step(0, 1'b0, 1'b1, pix_data(0, p));
    chk("pre_rst_col", ocol[0], 2'd1);
    iv[0] = 1'b1;
    id[0] = pix_data(0, 9);
    #3;
    rst_cnn = 1'b0;
    #1;
    chk("mid_rst_data", od[0], '0);
    chk("mid_rst_col", ocol[0], 2'd0);
    chk("mid_rst_valid", ov[0], 1'b0);
    chk("mid_rst_busy", bz[0], 1'b0);
    @(negedge clk);
    iv[0] = 1'b0;
    rst_cnn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(0, 1'b0, 1'b1, pack4(77, 77, 77, 77));
      chk("idle_ignore_valid", ov[0], 1'b0);
      chk("idle_ignore_busy", bz[0], 1'b0);
    end
    run_frame(0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Streaming post-convolution stage that sits directly downstream of the convolution PE array. It accepts one output-feature-map pixel per cycle, carrying all NUM_FEATURES channels, in raster order. It applies ReLU and 2x2 stride-2 max pooling using a one-pooled-row line buffer, and emits one pooled pixel (all channels) per completed window together with its pooled coordinates. The reduced map feeds the later classifier layers.

## Interface
- NUM_FEATURES, 10: channels per pixel.
- IN_WIDTH, 26: input map width (convolution output width).
- IN_HEIGHT, 26: input map height.
- DATA_W, 32: signed pixel width; input and output use the same width.
- Derived: OUT_WIDTH = IN_WIDTH/2 and OUT_HEIGHT = IN_HEIGHT/2 (floor).

- clk  in  1  posedge clock.
- rst_cnn  in  1  reset, asynchronous, active-low.
- frame_start  in  1  single-cycle pulse; clears counters and line buffer and arms a new frame.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  [NUM_FEATURES][DATA_W] signed  one pixel, all channels.
- out_valid  out  1  out_data, out_row and out_col are valid this cycle.
- out_data  out  [NUM_FEATURES][DATA_W] signed  pooled maxima; each value is >= 0.
- out_row  out  $clog2(OUT_HEIGHT+1)  pooled row index.
- out_col  out  $clog2(OUT_WIDTH+1)  pooled column index.
- frame_done  out  1  single-cycle pulse after the last input pixel of the frame is accepted.
- busy  out  1  high in RUN.

## Operation
- States:
  - IDLE: after reset. frame_start -> RUN.
  - RUN: pixels are accepted when in_valid is high.
  - DONE: entered after the pixel at (IN_HEIGHT-1, IN_WIDTH-1) is accepted. in_valid is ignored. frame_start -> RUN.
  - In IDLE, in_valid without frame_start is ignored.
- frame_start has priority in any state: counters row=col=0, line buffer cleared. If in_valid is high in the same cycle, that pixel is accepted as (0,0).
- Counters advance per accepted pixel: col increments; when col==IN_WIDTH-1, col wraps to 0 and row increments.
- ReLU per channel: r = (x<0) ? 0 : x. No saturation and no width change.
- Line buffer lb[OUT_WIDTH][NUM_FEATURES], indexed by pc = col>>1, pr = row>>1.
  - Pixels with row >= 2*OUT_HEIGHT or col >= 2*OUT_WIDTH (odd trailing row/column) are counted but discarded.
  - (even row, even col): lb[pc] <= r.
  - (even,odd) and (odd,even): lb[pc] <= max(lb[pc], r), signed compare per channel.
  - (odd,odd): out_data <= max(lb[pc], r); out_row <= pr; out_col <= pc; out_valid <= 1.
- Comparisons are signed. After ReLU, all operands are non-negative.
- Holes in in_valid are allowed. State holds when in_valid is low.

## Timing
- Reset values: out_valid=0, out_data all 0, out_row=0, out_col=0, frame_done=0, busy=0, state IDLE, counters 0, line buffer 0.
- Latency: out_valid rises 1 cycle after the (odd,odd) window-closing pixel is accepted. out_valid is high for exactly 1 cycle per window.
- out_data, out_row and out_col hold their last values while out_valid=0.
- frame_done pulses 1 cycle after the last pixel is accepted. With even dimensions it coincides with the final out_valid.
- busy=1 throughout RUN, including the last-pixel cycle. It drops with the transition to DONE.
- Throughput: 1 pixel/cycle with no stalls. There is no backpressure, so the consumer must accept out_valid every cycle.
- Reset assertion mid-frame: all outputs go to reset values immediately (asynchronously), and the partial frame is lost.
- frame_start mid-frame: the partial window is discarded. No out_valid or frame_done is produced for the aborted frame.

## Test plan
- 4x4 map, one channel, row-major values 1..16 streamed back-to-back after frame_start -> 4 outputs: (0,0)=6, (0,1)=8, (1,0)=14, (1,1)=16. frame_done coincides with the (1,1) output.
- 4x4 map, all channels -5 except channel 3 with -1,-2,-3,7 in window (0,0) -> window (0,0) outputs 0 on all channels except channel 3=7. All other windows are all 0.
- 5x5 map, values 1..25 -> exactly 4 outputs (7,9,17,19). Row 4 and column 4 are discarded. frame_done 1 cycle after pixel 25.
- 4x4 map with in_valid toggling 1,0,1,0... -> same results as the first scenario. Each out_valid lags its closing pixel by exactly 1 cycle.
- rst_cnn low during the 10th pixel of a 4x4 frame -> outputs are 0 immediately and the state is IDLE. After frame_start, a new frame of 1..16 gives the correct 6/8/14/16.
- After DONE, in_valid=1 with no frame_start -> no output. frame_start with in_valid in the same cycle -> that pixel counts as (0,0).
